// File: rtl/qproc_in_port_ctrl_pkg.sv
// qproc_in_port_ctrl_pkg: shared limits, read mode and read response types for the input-port capture unit
package qproc_in_port_ctrl_pkg;

    localparam int IN_PORT_MAX = 16;
    localparam int DW_MAX      = 128;
    localparam int CNT_W_MAX   = 16;

    typedef enum logic {
        RD_SAMPLE = 1'b0,
        RD_POP    = 1'b1
    } rd_mode_t;

    // Sized for the widest legal configuration; the top slices it down to DW / FIFO_AW+1.
    typedef struct packed {
        logic [DW_MAX-1:0]    dt;
        logic                 vld;
        logic                 empty;
        logic                 err;
        logic [CNT_W_MAX-1:0] cnt;
    } rd_rsp_t;

endpackage

// File: rtl/qproc_in_fifo.sv
// qproc_in_fifo: single-clock show-ahead FIFO with wrap-bit pointers; a pop frees room for a same-cycle push
module qproc_in_fifo #(
    parameter int DW      = 64,
    parameter int FIFO_AW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [DW-1:0]    din,
    output logic [DW-1:0]    dout,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] cnt
);

    logic [DW-1:0]    mem [2**FIFO_AW];
    logic [FIFO_AW:0] wptr, rptr;
    logic             do_push, do_pop;

    assign cnt     = wptr - rptr;
    assign empty   = cnt == '0;
    assign full    = cnt == (FIFO_AW+1)'(2**FIFO_AW);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= do_push ? wptr + (FIFO_AW+1)'(1) : wptr;
            rptr <= do_pop ? rptr + (FIFO_AW+1)'(1) : rptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[FIFO_AW-1:0]] <= din;
    end

endmodule

// File: rtl/qproc_in_port_ctrl.sv
// qproc_in_port_ctrl: per-port capture FIFOs, last-value registers and sticky flags with a one-cycle read port
module qproc_in_port_ctrl
    import qproc_in_port_ctrl_pkg::*;
#(
    parameter int IN_PORT_QTY = 4,
    parameter int DW          = 64,
    parameter int FIFO_AW     = 3,
    parameter int PA_W        = 4
) (
    input  logic                              c_clk_i,
    input  logic                              c_rst_i,
    input  logic [IN_PORT_QTY-1:0]            port_vld_i,
    input  logic [IN_PORT_QTY-1:0][DW-1:0]    port_dt_i,
    input  logic                              rd_req_i,
    input  logic [PA_W-1:0]                   rd_addr_i,
    input  logic                              rd_mode_i,
    input  logic                              clr_i,
    output logic [DW-1:0]                     rd_dt_o,
    output logic                              rd_vld_o,
    output logic                              rd_empty_o,
    output logic                              rd_err_o,
    output logic [FIFO_AW:0]                  rd_cnt_o,
    output logic [IN_PORT_QTY-1:0]            new_o,
    output logic [IN_PORT_QTY-1:0]            ovf_o,
    output logic                              any_new_o
);

    localparam int CW = FIFO_AW + 1;

    logic [IN_PORT_QTY-1:0][DW-1:0] last_dt, head;
    logic [IN_PORT_QTY-1:0][CW-1:0] cnt, cnt_nxt;
    logic [IN_PORT_QTY-1:0]         hit, pop, pop_ok, push_ok, full, empty, new_nxt, ovf_nxt;
    logic                           in_range;
    rd_mode_t                       mode;
    rd_rsp_t                        rsp, rsp_nxt;
    logic                           unused;

    assign in_range = 32'(rd_addr_i) < IN_PORT_QTY;
    assign mode     = rd_mode_t'(rd_mode_i);

    for (genvar p = 0; p < IN_PORT_QTY; p++) begin : g_port
        assign hit[p]     = rd_req_i && 32'(rd_addr_i) == p;
        assign pop[p]     = hit[p] && mode == RD_POP;
        assign pop_ok[p]  = pop[p] & ~empty[p];
        assign push_ok[p] = port_vld_i[p] & (~full[p] | pop_ok[p]);
        assign cnt_nxt[p] = cnt[p] + CW'(push_ok[p]) - CW'(pop_ok[p]);
        // Set wins over both a read of the port and clr_i.
        assign new_nxt[p] = port_vld_i[p] | (new_o[p] & ~clr_i & ~hit[p]);
        assign ovf_nxt[p] = (port_vld_i[p] & full[p] & ~pop_ok[p]) | (ovf_o[p] & ~clr_i);

        qproc_in_fifo #(
            .DW      (DW),
            .FIFO_AW (FIFO_AW)
        ) u_fifo (
            .clk   (c_clk_i),
            .rst   (c_rst_i),
            .push  (port_vld_i[p]),
            .pop   (pop[p]),
            .din   (port_dt_i[p]),
            .dout  (head[p]),
            .full  (full[p]),
            .empty (empty[p]),
            .cnt   (cnt[p])
        );
    end

    // dt and cnt hold between responses; out-of-range reads leave them zero.
    always_comb begin
        rsp_nxt       = rsp;
        rsp_nxt.vld   = rd_req_i;
        rsp_nxt.err   = rd_req_i & ~in_range;
        rsp_nxt.empty = 1'b0;
        rsp_nxt.dt    = rd_req_i ? '0 : rsp.dt;
        rsp_nxt.cnt   = rd_req_i ? '0 : rsp.cnt;
        for (int i = 0; i < IN_PORT_QTY; i++) begin
            if (hit[i]) begin
                rsp_nxt.dt    = DW_MAX'(pop[i] ? (empty[i] ? {DW{1'b0}} : head[i]) : last_dt[i]);
                rsp_nxt.empty = pop[i] & empty[i];
                rsp_nxt.cnt   = CNT_W_MAX'(cnt_nxt[i]);
            end
        end
    end

    always_ff @(posedge c_clk_i) begin
        if (c_rst_i) begin
            rsp       <= '0;
            last_dt   <= '0;
            new_o     <= '0;
            ovf_o     <= '0;
            any_new_o <= 1'b0;
        end else begin
            rsp       <= rsp_nxt;
            new_o     <= new_nxt;
            ovf_o     <= ovf_nxt;
            any_new_o <= |new_nxt;
            for (int i = 0; i < IN_PORT_QTY; i++) begin
                if (port_vld_i[i]) last_dt[i] <= port_dt_i[i];
            end
        end
    end

    assign rd_dt_o    = rsp.dt[DW-1:0];
    assign rd_vld_o   = rsp.vld;
    assign rd_empty_o = rsp.empty;
    assign rd_err_o   = rsp.err;
    assign rd_cnt_o   = rsp.cnt[CW-1:0];
    assign unused     = ^{rsp.dt, rsp.cnt};

endmodule
